// File: rtl/sram_pkg.sv
// Shared SRAM bus defaults and small helpers for the request controller
// and any SRAM model that pairs with it.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_WIDTH = 8;
    localparam int unsigned SRAM_DATA_WIDTH = 32;

    localparam int unsigned RSP_DEPTH_MIN = 2;
    localparam int unsigned RSP_DEPTH_MAX = 16;

    // Increment a buffer pointer, wrapping at depth (depth need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return ((ptr + 32'd1) >= depth) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Read-response buffer: circular store with occupancy count and
// pointers that wrap modulo the configured depth.
module sram_rsp_fifo
    import sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [DATA_WIDTH-1:0]              din,
    output logic [DATA_WIDTH-1:0]              dout,
    output logic [$clog2(RSP_DEPTH + 1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RSP_DEPTH));
    assign do_pop  = pop && !empty;
    // Upstream credit gating keeps push-when-full from ever happening.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), RSP_DEPTH));
            end
            if (do_pop) begin
                rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), RSP_DEPTH));
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sram_req_ctrl.sv
// Request front end for a single-port SRAM with registered read data;
// reads are buffered in a credit-controlled response FIFO.
module sram_req_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_cs,
    output logic                  sram_rwb,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned CRD_W = CNT_W + 1;

    if (RSP_DEPTH < RSP_DEPTH_MIN || RSP_DEPTH > RSP_DEPTH_MAX) begin : g_bad_depth
        $error("sram_req_ctrl: RSP_DEPTH must be in 2..16");
    end

    logic                  rd_pend;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CRD_W-1:0]      credit;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  rsp_fire;

    // Credit counts both buffered responses and the read still in flight
    // inside the SRAM, so ready depends on registered state only.
    assign credit    = CRD_W'(fifo_count) + CRD_W'(rd_pend);
    assign req_ready = (credit < CRD_W'(RSP_DEPTH)) && !rst;

    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_we;

    assign sram_cs    = req_fire;
    assign sram_rwb   = req_we;
    assign sram_addr  = req_addr;
    assign sram_wdata = req_wdata;

    assign rsp_valid = (fifo_count != '0) && !rst;
    assign rsp_rdata = rsp_valid ? fifo_dout : '0;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // One-cycle marker aligning the SRAM's registered read data with the push.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_fire;
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pend),
        .pop   (rsp_fire),
        .din   (sram_rdata),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    // Outstanding reads can never exceed the buffer space.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (credit <= CRD_W'(RSP_DEPTH));
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: SRAM model, directed scenarios and
// a randomized phase, checked against a queue-based reference model.
module tb_sram_req_ctrl;
    import sram_pkg::*;

    localparam int unsigned AW    = SRAM_ADDR_WIDTH;
    localparam int unsigned DW    = SRAM_DATA_WIDTH;
    localparam int unsigned DEPTH = 2;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cs;
    logic          sram_rwb;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    sram_req_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_cs    (sram_cs),
        .sram_rwb   (sram_rwb),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return DW'({4{a}}) ^ 32'hA5C3_0F69;
    endfunction

    // SRAM model with registered read data
    logic [DW-1:0] sram_mem  [2**AW];
    bit            sram_seen [2**AW];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_rwb) begin
                sram_mem[sram_addr]  <= sram_wdata;
                sram_seen[sram_addr] <= 1'b1;
            end else begin
                sram_rdata <= sram_seen[sram_addr] ? sram_mem[sram_addr] : init_word(sram_addr);
            end
        end
    end

    // Reference: memory contents plus outstanding reads in request order
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [int];
    int unsigned   edge_n;
    int unsigned   n_acc_rd;
    int unsigned   checks;
    int unsigned   errors;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, check every output against the model, advance model.
    task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        logic          exp_ready;
        logic          exp_valid;
        logic [DW-1:0] exp_rdata;
        logic          acc;
        logic          pop;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = rr;
        #1;
        exp_ready = !rst && (q.size() < DEPTH);
        exp_valid = 1'b0;
        if (!rst && q.size() > 0) begin
            exp_valid = (q[0].cyc + 2 <= edge_n);
        end
        exp_rdata = exp_valid ? q[0].data : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        chk("sram_cs",   64'(sram_cs),   64'(v && exp_ready));
        if (v && exp_ready) begin
            chk("sram_rwb",   64'(sram_rwb),   64'(we));
            chk("sram_addr",  64'(sram_addr),  64'(a));
            chk("sram_wdata", 64'(sram_wdata), 64'(d));
        end
        acc = v && exp_ready;
        pop = exp_valid && rr;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (we) begin
                    ref_mem[int'(a)] = d;
                end else begin
                    q.push_back('{ref_rd(a), edge_n});
                    n_acc_rd++;
                end
            end
        end
        edge_n++;
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    int unsigned acc_start;

    initial begin
        checks    = 0;
        errors    = 0;
        edge_n    = 0;
        n_acc_rd  = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        // Reset: outputs quiet even with a request presented
        cycle(1'b1, 1'b0, 8'h05, '0, 1'b1);
        cycle(1'b1, 1'b1, 8'h06, 32'h1234_5678, 1'b1);
        rst = 1'b0;
        idle(2);

        // Write then read same address: one-cycle response two edges after accept
        cycle(1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b1, 1'b0, 8'h10, '0, 1'b1);
        chk("wr_rd_pend_valid", 64'(rsp_valid), 64'd0);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        chk("wr_rd_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rd_data",  64'(rsp_rdata), 64'hDEAD_BEEF);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        chk("wr_rd_one_shot", 64'(rsp_valid), 64'd0);
        idle(2);

        // Backpressure: two reads fill the credit, third waits for a pop
        cycle(1'b1, 1'b1, 8'h01, 32'h01, 1'b0);
        cycle(1'b1, 1'b1, 8'h02, 32'h02, 1'b0);
        cycle(1'b1, 1'b1, 8'h03, 32'h03, 1'b0);
        cycle(1'b1, 1'b0, 8'h01, '0, 1'b0);
        cycle(1'b1, 1'b0, 8'h02, '0, 1'b0);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        cycle(1'b1, 1'b0, 8'h03, '0, 1'b0);
        cycle(1'b1, 1'b0, 8'h03, '0, 1'b0);
        chk("bp_head_first", 64'(rsp_rdata), 64'h01);
        cycle(1'b1, 1'b0, 8'h03, '0, 1'b1);
        chk("bp_head_second", 64'(rsp_rdata), 64'h02);
        chk("bp_ready_back",  64'(req_ready), 64'd1);
        cycle(1'b1, 1'b0, 8'h03, '0, 1'b1);
        idle(4);
        chk("bp_drained", 64'(rsp_valid), 64'd0);

        // Continuous reads: at least one accept per two cycles, count near 1
        acc_start = n_acc_rd;
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, AW'(i), '0, 1'b1);
        chk("throughput", 64'((n_acc_rd - acc_start) >= 20), 64'd1);
        idle(4);

        // Reset one cycle after a read accept drops it
        cycle(1'b1, 1'b0, 8'h02, '0, 1'b1);
        rst = 1'b1;
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            chk("rst_flush_valid", 64'(rsp_valid), 64'd0);
        end
        cycle(1'b1, 1'b0, 8'h10, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, '0, 1'b1);
        chk("post_rst_valid", 64'(rsp_valid), 64'd1);
        chk("post_rst_data",  64'(rsp_rdata), 64'hDEAD_BEEF);
        idle(3);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 80) == 0);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  AW'(8'h20 + $urandom_range(0, 7)), DW'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        idle(8);
        chk("final_empty", 64'(rsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
